game_stats_bcd: RTL

- Upstream feeder of the status-text renderer. Keeps the SCORE, LINES and LEVEL counters as packed BCD digit arrays; the renderer adds 0x30 to each digit to get ASCII.
- Accepts one "lines cleared" event at a time from the game-logic FSM over a valid/ready handshake.
- Score update is digit-serial: repeated BCD addition of a base award, committed atomically so the display never shows a partial sum.

---
 rtl/game_stats_bcd.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/game_stats_bcd.sv
// Keeps SCORE/LINES/LEVEL as packed BCD digits for the status-text renderer.
// Latency: lines/level 2 cycles after accept; score 2 + NUMBER_LEN*(level+1) cycles.
// Backpressure: clr_ready_o drops for the whole operation; an event is taken only when idle.
module game_stats_bcd #(
  parameter int NUMBER_LEN      = 6,
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 29
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        new_game_i,
  input  logic                        clr_valid_i,
  input  logic [2:0]                  clr_lines_i,
  output logic                        clr_ready_o,
  output logic                        done_o,
  output logic [NUMBER_LEN-1:0][3:0]  score_o,
  output logic [NUMBER_LEN-1:0][3:0]  lines_o,
  output logic [NUMBER_LEN-1:0][3:0]  level_o
);

  localparam int LW = $clog2(MAX_LEVEL + 1);
  localparam int IW = $clog2(MAX_LEVEL + 2);
  localparam int DW = $clog2(NUMBER_LEN);
  localparam int CW = 5;

  typedef logic [NUMBER_LEN-1:0][3:0] bcd_t;
  typedef enum logic [1:0] {IDLE, LINES, SCORE} state_t;

  localparam bcd_t ALL_NINES = {NUMBER_LEN{4'h9}};

  // Adds a small binary value (0..9) to a BCD number; MSB of the result is the carry out.
  function automatic logic [NUMBER_LEN*4:0] bcd_add_small(input bcd_t a, input logic [3:0] v);
    bcd_t       r;
    logic [4:0] s;
    logic [3:0] c;
    c = v;
    r = '0;
    for (int i = 0; i < NUMBER_LEN; i++) begin
      s = {1'b0, a[i]} + {1'b0, c};
      if (s > 5'd9) begin
        r[i] = 4'(s - 5'd10);
        c    = 4'd1;
      end else begin
        r[i] = s[3:0];
        c    = 4'd0;
      end
    end
    return {c[0], r};
  endfunction

  // Base award per cleared-line count, as BCD digits: 0/40/100/300/1200.
  function automatic bcd_t base_award(input logic [2:0] n);
    bcd_t r;
    r = '0;
    case (n)
      3'd1:    r[1] = 4'd4;
      3'd2:    r[2] = 4'd1;
      3'd3:    r[2] = 4'd3;
      3'd4:    begin r[3] = 4'd1; r[2] = 4'd2; end
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t          state;
  logic [2:0]      n_q;
  bcd_t            b_q;
  logic [IW-1:0]   m_q;
  logic [IW-1:0]   iter;
  logic [DW-1:0]   dig;
  bcd_t            acc;
  logic            carry;
  logic            sat;
  logic [LW-1:0]   level_bin;
  logic [CW-1:0]   lvl_cnt;

  logic [2:0]              n_clamp;
  logic [NUMBER_LEN*4:0]   lines_sum;
  bcd_t                    level_inc;
  logic [CW-1:0]           lvl_sum;
  logic [4:0]              dsum;
  logic                    dcarry;
  bcd_t                    acc_next;

  // Clamp input, precompute counter updates and one digit of the serial score add.
  always_comb begin
    n_clamp   = (clr_lines_i > 3'd4) ? 3'd4 : clr_lines_i;
    lines_sum = bcd_add_small(lines_o, {1'b0, n_q});
    level_inc = bcd_t'(bcd_add_small(level_o, 4'd1));
    lvl_sum   = lvl_cnt + CW'(n_q);
    // carry restarts at digit 0 of every iteration
    dsum      = {1'b0, acc[dig]} + {1'b0, b_q[dig]} + {4'd0, (dig != '0) & carry};
    dcarry    = 1'b0;
    acc_next  = acc;
    if (dsum > 5'd9) begin
      acc_next[dig] = 4'(dsum - 5'd10);
      dcarry        = 1'b1;
    end else begin
      acc_next[dig] = dsum[3:0];
    end
  end

  // Control FSM and all counter/output registers; new_game_i behaves like reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || new_game_i) begin
      state       <= IDLE;
      n_q         <= '0;
      b_q         <= '0;
      m_q         <= '0;
      iter        <= '0;
      dig         <= '0;
      acc         <= '0;
      carry       <= 1'b0;
      sat         <= 1'b0;
      level_bin   <= '0;
      lvl_cnt     <= '0;
      score_o     <= '0;
      lines_o     <= '0;
      level_o     <= '0;
      done_o      <= 1'b0;
      clr_ready_o <= 1'b1;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          clr_ready_o <= 1'b1;
          if (clr_valid_i && clr_ready_o) begin
            n_q         <= n_clamp;
            b_q         <= base_award(n_clamp);
            m_q         <= IW'(level_bin) + IW'(1);
            acc         <= score_o;
            clr_ready_o <= 1'b0;
            state       <= LINES;
          end
        end
        LINES: begin
          lines_o <= lines_sum[NUMBER_LEN*4] ? ALL_NINES : bcd_t'(lines_sum);
          if (lvl_sum >= CW'(LINES_PER_LEVEL)) begin
            lvl_cnt <= lvl_sum - CW'(LINES_PER_LEVEL);
            if (level_bin < LW'(MAX_LEVEL)) begin
              level_bin <= level_bin + LW'(1);
              level_o   <= level_inc;
            end
          end else begin
            lvl_cnt <= lvl_sum;
          end
          iter  <= '0;
          dig   <= '0;
          carry <= 1'b0;
          sat   <= 1'b0;
          if (n_q == 3'd0) begin
            done_o      <= 1'b1;
            clr_ready_o <= 1'b1;
            state       <= IDLE;
          end else begin
            state <= SCORE;
          end
        end
        SCORE: begin
          acc   <= acc_next;
          carry <= dcarry;
          if (dig == DW'(NUMBER_LEN - 1)) begin
            sat <= sat | dcarry;
            dig <= '0;
            if (iter == m_q - IW'(1)) begin
              score_o     <= (sat | dcarry) ? ALL_NINES : acc_next;
              done_o      <= 1'b1;
              clr_ready_o <= 1'b1;
              state       <= IDLE;
            end else begin
              iter <= iter + IW'(1);
            end
          end else begin
            dig <= dig + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
